// File: rtl/sha3_stream_padder.sv
// sha3_stream_padder
//   Packs a valid/ready byte stream of W-byte beats into R-bit rate blocks for
//   the keccak core and applies FIPS 202 domain-separation padding
//   (DOMAIN = 8'h06 for SHA-3, 8'h1F for SHAKE).
//
// Parameters
//   D       capacity/2 (digest length); rate R = 1600 - 2*D (derived, fixed)
//   W       bytes per input beat; (R/8) % W must be 0
//   DOMAIN  domain suffix byte
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   in_data    W message bytes, byte 0 in the most significant byte lane
//   in_nbytes  valid byte count on a last beat (0..W, larger values mean W)
//   in_last    beat ends the message
//   in_valid   beat offered
//   in_ready   beat accepted when in_valid & in_ready
//   blk_data   rate block, block byte k at blk_data[R-1-8k -: 8]
//   blk_valid  blk_data holds a complete block
//   blk_ready  core takes the block when blk_valid & blk_ready
//   blk_last   block is the final, padded block of the message
module sha3_stream_padder #(
    parameter int         D      = 256,
    parameter int         W      = 8,
    parameter logic [7:0] DOMAIN = 8'h06,
    localparam int        R      = 1600 - 2*D
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [8*W-1:0]             in_data,
    input  logic [$clog2(W+1)-1:0]     in_nbytes,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [R-1:0]               blk_data,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic                       blk_last
);

    localparam int RB = R / 8;
    localparam int CW = $clog2(RB + 1);
    localparam logic [CW-1:0] RB_C = CW'(RB);
    localparam logic [CW-1:0] W_C  = CW'(W);

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] PADBLK = 2'd2;

    if ((RB % W) != 0) begin : g_bad_width
        $error("sha3_stream_padder: rate in bytes must be a multiple of W");
    end

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic          rdy;
    logic          pad_pend;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nb;
    logic [CW-1:0] pos_end;
    logic [R-1:0]  nxt;
    logic [7:0]    b;

    assign in_ready  = rdy;
    assign blk_valid = (state == HOLD);

    // Bytes carried by the current beat, clamped to W.
    always_comb begin
        if (in_last && (int'(in_nbytes) < W))
            nb = CW'(in_nbytes);
        else
            nb = W_C;
        pos_end = cnt + nb;
    end

    // Block contents after accepting the current beat. Unwritten bytes are
    // already zero because the buffer is cleared on every handshake.
    always_comb begin
        nxt = blk_data;
        b   = '0;
        for (int unsigned k = 0; k < RB; k++) begin
            b = blk_data[R-1-8*k -: 8];
            if ((k >= 32'(cnt)) && (k < 32'(pos_end)))
                b = in_data[8*W-1-8*(k-32'(cnt)) -: 8];
            if (in_last && (pos_end < RB_C)) begin
                if (k == 32'(pos_end))
                    b = DOMAIN;
                if (k == RB - 1)
                    b = b | 8'h80;
            end
            nxt[R-1-8*k -: 8] = b;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            FILL:    if (in_valid && rdy && (in_last || (pos_end == RB_C)))
                         state_n = HOLD;
            HOLD:    if (blk_ready)
                         state_n = pad_pend ? PADBLK : FILL;
            PADBLK:  state_n = HOLD;
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            rdy      <= 1'b0;
            pad_pend <= 1'b0;
            cnt      <= '0;
            blk_data <= '0;
            blk_last <= 1'b0;
        end else begin
            state <= state_n;
            // Ready is registered from the next state, so it never depends
            // combinationally on blk_ready.
            rdy   <= (state_n == FILL);
            case (state)
                FILL: begin
                    if (in_valid && rdy) begin
                        blk_data <= nxt;
                        cnt      <= pos_end;
                        // A last beat that exactly fills the block leaves no
                        // room for padding: emit it unpadded, pad block next.
                        blk_last <= in_last && (pos_end != RB_C);
                        pad_pend <= in_last && (pos_end == RB_C);
                    end
                end
                HOLD: begin
                    if (blk_ready) begin
                        blk_data <= '0;
                        cnt      <= '0;
                        blk_last <= 1'b0;
                    end
                end
                PADBLK: begin
                    blk_data <= {DOMAIN, {(R-16){1'b0}}, 8'h80};
                    blk_last <= 1'b1;
                    pad_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_stream_padder.sv
module tb_sha3_stream_padder;

    localparam int RA  = 1088;  // SHA3-256 rate bits
    localparam int RBS = 1344;  // SHAKE128 rate bits

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: SHA3-256
    logic          a_rst = 1'b0;
    logic [63:0]   a_in_data = '0;
    logic [3:0]    a_nbytes = '0;
    logic          a_last = 1'b0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [RA-1:0] a_blk;
    logic          a_bv;
    logic          a_br = 1'b0;
    logic          a_bl;

    // DUT B: SHAKE128
    logic           b_rst = 1'b0;
    logic [63:0]    b_in_data = '0;
    logic [3:0]     b_nbytes = '0;
    logic           b_last = 1'b0;
    logic           b_valid = 1'b0;
    logic           b_ready;
    logic [RBS-1:0] b_blk;
    logic           b_bv;
    logic           b_br = 1'b0;
    logic           b_bl;

    sha3_stream_padder #(.D(256), .W(8), .DOMAIN(8'h06)) dut_a (
        .clk(clk), .reset(a_rst), .in_data(a_in_data), .in_nbytes(a_nbytes),
        .in_last(a_last), .in_valid(a_valid), .in_ready(a_ready),
        .blk_data(a_blk), .blk_valid(a_bv), .blk_ready(a_br), .blk_last(a_bl)
    );

    sha3_stream_padder #(.D(128), .W(8), .DOMAIN(8'h1F)) dut_b (
        .clk(clk), .reset(b_rst), .in_data(b_in_data), .in_nbytes(b_nbytes),
        .in_last(b_last), .in_valid(b_valid), .in_ready(b_ready),
        .blk_data(b_blk), .blk_valid(b_bv), .blk_ready(b_br), .blk_last(b_bl)
    );

    function automatic logic [7:0] msgb(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Software-padded SHA3-256 reference: len message bytes starting at
    // message index base, padding only when the message ends inside the block.
    function automatic logic [RA-1:0] exp_a(input int base, input int len);
        logic [RA-1:0] e;
        e = '0;
        for (int k = 0; k < len; k++) e[RA-1-8*k -: 8] = msgb(base + k);
        if (len < 136) begin
            e[RA-1-8*len -: 8] = 8'h06;
            e[7:0] = e[7:0] | 8'h80;
        end
        return e;
    endfunction

    function automatic logic [RBS-1:0] exp_b_abc();
        logic [RBS-1:0] e;
        e = '0;
        e[RBS-1 -: 32] = 32'h6162631F;
        e[7:0] = 8'h80;
        return e;
    endfunction

    function automatic int diff_a(input logic [RA-1:0] x, input logic [RA-1:0] y);
        for (int k = 0; k < RA/8; k++)
            if (x[RA-1-8*k -: 8] !== y[RA-1-8*k -: 8]) return k;
        return -1;
    endfunction

    function automatic int diff_b(input logic [RBS-1:0] x, input logic [RBS-1:0] y);
        for (int k = 0; k < RBS/8; k++)
            if (x[RBS-1-8*k -: 8] !== y[RBS-1-8*k -: 8]) return k;
        return -1;
    endfunction

    // Offer one beat on DUT A and hold it until accepted. Unused lanes carry
    // 8'hEE so that any leakage into the block is visible.
    task automatic a_send(input int base, input int n, input logic last);
        int cyc;
        for (int j = 0; j < 8; j++)
            a_in_data[63-8*j -: 8] = (j < n) ? msgb(base + j) : 8'hEE;
        a_nbytes = 4'(n);
        a_last   = last;
        a_valid  = 1'b1;
        cyc = 0;
        while (a_ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL a_send_timeout in_ready=%b required 1", a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic b_send(input logic [63:0] d, input int n, input logic last);
        int cyc;
        b_in_data = d;
        b_nbytes  = 4'(n);
        b_last    = last;
        b_valid   = 1'b1;
        cyc = 0;
        while (b_ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL b_send_timeout in_ready=%b required 1", b_ready);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    task automatic a_take();
        int cyc;
        a_br = 1'b1;
        cyc = 0;
        while (a_bv !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL a_take_timeout blk_valid=%b required 1", a_bv);
        end
        @(posedge clk); #1;
        a_br = 1'b0;
    endtask

    task automatic b_take();
        int cyc;
        b_br = 1'b1;
        cyc = 0;
        while (b_bv !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL b_take_timeout blk_valid=%b required 1", b_bv);
        end
        @(posedge clk); #1;
        b_br = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({a_ready, a_bv, a_bl, b_ready, b_bv, b_bl} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000000",
                     {a_ready, a_bv, a_bl, b_ready, b_bv, b_bl});
        end
        checks++;
        if (a_blk !== '0 || b_blk !== '0) begin
            errors++;
            $display("FAIL reset_data got a_byte0=%h b_byte0=%h required 00",
                     a_blk[RA-1 -: 8], b_blk[RBS-1 -: 8]);
        end
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b required 0", a_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b%b required 11", a_ready, b_ready);
        end
    endtask

    task automatic test_empty();
        int k;
        a_send(0, 0, 1'b1);
        checks++;
        if (a_bv !== 1'b1 || a_bl !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_ctrl got v=%b l=%b r=%b required v=1 l=1 r=0",
                     a_bv, a_bl, a_ready);
        end
        checks++;
        if (a_blk !== exp_a(0, 0)) begin
            errors++;
            k = diff_a(a_blk, exp_a(0, 0));
            $display("FAIL empty_block byte %0d got %h required %h", k,
                     a_blk[RA-1-8*k -: 8], exp_a(0, 0) >> (RA-8-8*k));
        end
        a_take();
        checks++;
        if (a_bv !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_after_take got v=%b r=%b required v=0 r=1", a_bv, a_ready);
        end
    endtask

    task automatic test_abc();
        int k;
        b_send({8'h61, 8'h62, 8'h63, 40'hEEEEEEEEEE}, 3, 1'b1);
        checks++;
        if (b_bv !== 1'b1 || b_bl !== 1'b1) begin
            errors++;
            $display("FAIL abc_ctrl got v=%b l=%b required v=1 l=1", b_bv, b_bl);
        end
        checks++;
        if (b_blk !== exp_b_abc()) begin
            errors++;
            k = diff_b(b_blk, exp_b_abc());
            $display("FAIL abc_block byte %0d got %h required %h", k,
                     b_blk[RBS-1-8*k -: 8], exp_b_abc() >> (RBS-8-8*k));
        end
        b_take();
    endtask

    task automatic test_135();
        int k;
        for (int i = 0; i < 16; i++) a_send(8*i, 8, 1'b0);
        checks++;
        if (a_bv !== 1'b0) begin
            errors++;
            $display("FAIL m135_early_valid got %b required 0", a_bv);
        end
        a_send(128, 7, 1'b1);
        checks++;
        if (a_bv !== 1'b1 || a_bl !== 1'b1 || a_blk[7:0] !== 8'h86) begin
            errors++;
            $display("FAIL m135_ctrl got v=%b l=%b b135=%h required v=1 l=1 b135=86",
                     a_bv, a_bl, a_blk[7:0]);
        end
        checks++;
        if (a_blk !== exp_a(0, 135)) begin
            errors++;
            k = diff_a(a_blk, exp_a(0, 135));
            $display("FAIL m135_block byte %0d got %h required %h", k,
                     a_blk[RA-1-8*k -: 8], exp_a(0, 135) >> (RA-8-8*k));
        end
        a_take();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_bv !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL m135_single_block got v=%b r=%b required v=0 r=1", a_bv, a_ready);
        end
    endtask

    task automatic test_136();
        int k;
        logic [RA-1:0] padb;
        padb = '0;
        padb[RA-1 -: 8] = 8'h06;
        padb[7:0] = 8'h80;
        for (int i = 0; i < 16; i++) a_send(8*i, 8, 1'b0);
        a_send(128, 8, 1'b1);
        checks++;
        if (a_bv !== 1'b1 || a_bl !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL m136_blk1_ctrl got v=%b l=%b r=%b required v=1 l=0 r=0",
                     a_bv, a_bl, a_ready);
        end
        checks++;
        if (a_blk !== exp_a(0, 136)) begin
            errors++;
            k = diff_a(a_blk, exp_a(0, 136));
            $display("FAIL m136_blk1 byte %0d got %h required %h", k,
                     a_blk[RA-1-8*k -: 8], exp_a(0, 136) >> (RA-8-8*k));
        end
        a_take();
        checks++;
        if (a_bv !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL m136_padcycle got v=%b r=%b required v=0 r=0", a_bv, a_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_bv !== 1'b1 || a_bl !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL m136_blk2_ctrl got v=%b l=%b r=%b required v=1 l=1 r=0",
                     a_bv, a_bl, a_ready);
        end
        checks++;
        if (a_blk !== padb) begin
            errors++;
            k = diff_a(a_blk, padb);
            $display("FAIL m136_blk2 byte %0d got %h required %h", k,
                     a_blk[RA-1-8*k -: 8], padb >> (RA-8-8*k));
        end
        a_take();
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL m136_ready_after got %b required 1", a_ready);
        end
    endtask

    task automatic test_backpressure();
        int k;
        a_send(200, 8, 1'b0);
        a_send(208, 8, 1'b0);
        a_send(216, 4, 1'b1);
        // Offer the first beat of the next message while the block is held.
        for (int j = 0; j < 8; j++) a_in_data[63-8*j -: 8] = msgb(300 + j);
        a_nbytes = 4'd8;
        a_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            a_valid = (c % 2 == 0);
            @(posedge clk); #1;
            checks++;
            if (a_ready !== 1'b0 || a_bv !== 1'b1 || a_bl !== 1'b1) begin
                errors++;
                $display("FAIL bp_ctrl cycle %0d got r=%b v=%b l=%b required r=0 v=1 l=1",
                         c, a_ready, a_bv, a_bl);
            end
            checks++;
            if (a_blk !== exp_a(200, 20)) begin
                errors++;
                k = diff_a(a_blk, exp_a(200, 20));
                $display("FAIL bp_hold cycle %0d byte %0d got %h required %h", c, k,
                         a_blk[RA-1-8*k -: 8], exp_a(200, 20) >> (RA-8-8*k));
            end
        end
        a_valid = 1'b0;
        a_take();
        a_send(300, 8, 1'b0);
        a_send(308, 8, 1'b0);
        a_send(316, 0, 1'b1);
        checks++;
        if (a_blk !== exp_a(300, 16) || a_bl !== 1'b1) begin
            errors++;
            k = diff_a(a_blk, exp_a(300, 16));
            $display("FAIL bp_next_msg l=%b byte %0d got %h required %h", a_bl, k,
                     a_blk[RA-1-8*k -: 8], exp_a(300, 16) >> (RA-8-8*k));
        end
        a_take();
    endtask

    task automatic test_reset_mid();
        int k;
        logic [63:0] d;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++) d[63-8*j -: 8] = msgb(500 + 8*i + j);
            b_send(d, 8, 1'b0);
        end
        @(posedge clk);
        #3;
        b_rst = 1'b1;
        #1;
        checks++;
        if ({b_ready, b_bv, b_bl} !== 3'b0 || b_blk !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got r=%b v=%b l=%b byte0=%h required all 0",
                     b_ready, b_bv, b_bl, b_blk[RBS-1 -: 8]);
        end
        @(posedge clk); #1;
        b_rst = 1'b0;
        @(posedge clk); #1;
        b_send({8'h61, 8'h62, 8'h63, 40'hEEEEEEEEEE}, 3, 1'b1);
        checks++;
        if (b_blk !== exp_b_abc() || b_bl !== 1'b1 || b_bv !== 1'b1) begin
            errors++;
            k = diff_b(b_blk, exp_b_abc());
            $display("FAIL midreset_abc v=%b l=%b byte %0d got %h required %h", b_bv, b_bl, k,
                     b_blk[RBS-1-8*k -: 8], exp_b_abc() >> (RBS-8-8*k));
        end
        b_take();
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_135();
        test_136();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha3_stream_padder.md
# sha3_stream_padder

Byte-stream front end for the `keccak` core: it takes a message as a valid/ready stream of W-byte beats and packs it into rate-sized blocks. It applies FIPS 202 domain-separation padding in hardware, covering SHA-3 (`8'h06`) and SHAKE (`8'h1F`). It hands complete blocks to the core over a valid/ready handshake, with a flag on the final block. This replaces the padding the testbenches currently do in software. It also adds multi-byte beats, selectable domain suffix and backpressure.

## Interface
- `D`, default 256: capacity/2 (SHA-3 digest length).
- `R`, derived as 1600-2*D: rate in bits.
  - Not overridable.
  - (R/8) % W must be 0; elaboration fails otherwise.
- `W`, default 8: bytes per input beat.
- `DOMAIN`, default `8'h06`: domain suffix byte. Use `8'h06` for SHA-3 and `8'h1F` for SHAKE.
- `clk`, input, width 1: the only clock. All logic updates on the rising edge.
- `reset`, input, width 1: asynchronous, active-high.
- `in_data`, input, width 8*W: message bytes. Byte 0 is `in_data[8*W-1 -: 8]`, the first in message order.
- `in_nbytes`, input, width $clog2(W+1):
  - Number of valid bytes on a last beat, 0..W.
  - Ignored on non-last beats, which always carry W bytes.
  - Values above W are treated as W.
- `in_last`, input, width 1: the beat ends the message.
- `in_valid`, input, width 1: the beat is offered.
- `in_ready`, output, width 1: the beat is accepted when `in_valid & in_ready`.
- `blk_data`, output, width R: block for the core. Block byte k sits at `blk_data[R-1-8k -: 8]`.
- `blk_valid`, output, width 1: `blk_data` holds a complete block.
- `blk_ready`, input, width 1: the core takes the block when `blk_valid & blk_ready`.
- `blk_last`, output, width 1: qualified by `blk_valid`. The block is the final, padded block of the message.

## Operation
- State machine with three states: FILL, HOLD and PADBLK. A byte counter `cnt` runs 0..R/8 and gives the next free block byte position.
- `in_ready` = (state == FILL). It is a registered decode and has no combinational path from `blk_ready`.
- **FILL, accepted non-last beat:**
  - The W bytes are written at `cnt..cnt+W-1`, then `cnt += W`.
  - If `cnt` reaches R/8, go to HOLD with `blk_last=0` and mark the message as still open.
- **FILL, accepted last beat with n bytes:**
  - The n bytes are written at `cnt..`, giving end position p = cnt+n.
  - If p < R/8:
    - Byte p gets `DOMAIN`. Byte R/8-1 gets OR `8'h80`, so if p = R/8-1 the byte is `DOMAIN | 8'h80`.
    - All other unused bytes are 0.
    - Go to HOLD with `blk_last=1`.
  - If p = R/8, go to HOLD with `blk_last=0` and flag a padding block as pending.
- **HOLD:**
  - `blk_valid=1`, and `blk_data`/`blk_last` stay stable until the handshake.
  - On the handshake, clear `blk_data` to 0 and set `cnt=0`.
  - Next state: PADBLK if a padding block is pending, otherwise FILL.
- **PADBLK:**
  - Lasts one cycle and accepts no input.
  - Loads byte 0 = `DOMAIN`, byte R/8-1 = `8'h80`, all else 0, with `blk_last=1`.
  - Then goes to HOLD.
- After the handshake of a `blk_last=1` block, return to FILL with `cnt=0`. This is the start of the next message.
- Empty message (a last beat with n=0 at cnt=0) produces one padding-only block.
- `in_valid` with `in_ready=0` has no effect. The source must hold the beat.

## Timing
- **Reset (asynchronous, takes effect immediately):**
  - state=FILL, `cnt=0`, `blk_data=0`, `blk_valid=0`, `blk_last=0`, padding-pending flag cleared.
  - `in_ready=0` while `reset` is high and 1 from the first edge after release.
  - Reset mid-message discards all partial data.
- `blk_valid` rises on the edge that accepts the completing beat. It is visible the cycle after that beat.
- A padding block becomes valid 2 cycles after the preceding block's handshake: one PADBLK cycle, then HOLD.
- After a `blk_valid & blk_ready` handshake, `in_ready` is 1 in the next cycle (the FILL case).
- Minimum cost is R/(8W) beats + 1 HOLD cycle per block.

## Test plan
- **Empty SHA-3 message** (D=256, W=8, R/8=136): one beat with `in_last=1`, n=0.
  - Required block: byte0=`06`, byte135=`80`, rest 0, `blk_last=1`.
  - `blk_valid` is high the cycle after the beat.
- **"abc" in SHAKE128** (D=128, `DOMAIN=8'h1F`, R/8=168): one beat with n=3.
  - Required bytes 0..3 = `61 62 63 1F`, byte167=`80`, rest 0.
- **135-byte message** (D=256): 16 full beats, then a last beat with n=7.
  - Required: byte135=`86`, exactly one block, `blk_last=1`.
- **136-byte message:** 17 beats, with n=8 on the last.
  - Block 1 holds the data with `blk_last=0`.
  - Block 2 is byte0=`06`, byte135=`80`, with `blk_last=1`, valid 2 cycles after the block 1 handshake.
  - `in_ready` stays 0 until block 2 is taken.
- **Backpressure:** hold `blk_ready=0` for 5 cycles while `in_valid` toggles.
  - `blk_data` and `blk_last` must stay stable and `in_ready` must stay 0.
  - No beat is lost or duplicated: the final block compares equal to the software-padded reference.
- **Reset mid-message:** assert `reset` asynchronously after 5 beats of message A, then send "abc".
  - All outputs are 0 during reset.
  - The first block matches the "abc" expectation, with no residue from A.
